// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one i2c master among N_REQ requesters
// Optional per-phase watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
    parameter int N_REQ          = 4,
    parameter int HOLD_CYCLES    = 100,
    parameter int GAP_CYCLES     = 1000,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_adrr_r_w,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic [7:0]         rdata,
    output logic               m_ena_i2c,
    output logic [7:0]         m_adrr_r_w,
    output logic [7:0]         m_byte_2_send,
    output logic               m_msb_lsb,
    input  logic [7:0]         m_byte_received,
    input  logic               m_end_trans
);
    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES);
`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD, GAP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ptr, win, idx;
    logic            end_q;
    logic            et_rise;
    logic            any_req;
    logic            cnt_zero;
    logic            wd_expired;
    logic            abort;

    assign et_rise    = m_end_trans & ~end_q;
    assign any_req    = |req;
    assign cnt_zero   = (cnt == '0);
    // In ADDR/DATA the shared counter doubles as the watchdog, counting up from 0.
    assign wd_expired = WD_EN && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign abort      = wd_expired && !et_rise && (state == ADDR || state == DATA);
    assign m_msb_lsb  = MSB_FIRST;

    // Round-robin pick: scan from farthest to nearest after ptr so the nearest set bit wins.
    always_comb begin
        win = ptr;
        idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = PW'((int'(ptr) + i) % N_REQ);
            if (req[idx]) win = idx;
        end
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (any_req) state_n = ADDR;
            ADDR: if (et_rise) state_n = DATA; else if (abort) state_n = GAP;
            DATA: if (et_rise) state_n = HOLD; else if (abort) state_n = GAP;
            HOLD: if (cnt_zero) state_n = GAP;
            GAP:  if (cnt_zero) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_n;
    end

    // Grant, latched master inputs, counter and read-data registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ptr           <= PW'(N_REQ - 1);
            cnt           <= '0;
            end_q         <= 1'b0;
            gnt           <= '0;
            done          <= '0;
            rdata         <= '0;
            m_ena_i2c     <= 1'b0;
            m_adrr_r_w    <= '0;
            m_byte_2_send <= '0;
        end else begin
            end_q <= m_end_trans;
            done  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt           <= N_REQ'(1) << win;
                        ptr           <= win;
                        m_ena_i2c     <= 1'b1;
                        cnt           <= '0;
                        m_adrr_r_w    <= req_adrr_r_w[8*int'(win) +: 8];
                        m_byte_2_send <= req_wdata[8*int'(win) +: 8];
                    end
                end
                ADDR, DATA: begin
                    if (et_rise) begin
                        if (state == DATA) begin
                            if (m_adrr_r_w[0]) rdata <= m_byte_received;
                            done <= gnt;
                            cnt  <= HOLD_LD;
                        end else begin
                            cnt <= '0;
                        end
                    end else if (abort) begin
                        m_ena_i2c <= 1'b0;
                        done      <= gnt;
                        gnt       <= '0;
                        cnt       <= GAP_LD;
                    end else if (WD_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        m_ena_i2c <= 1'b0;
                        gnt       <= '0;
                        cnt       <= GAP_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (!cnt_zero) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // Error flag pulses alongside done when the watchdog aborts a phase.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) err <= 1'b0;
        else      err <= abort;
    end
`else
    assign err = 1'b0;
`endif

endmodule
